// File: rtl/mux_pkg.sv
// Shared definitions for the two-requester stream arbiter.
//   state_t   : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   GRANT_W   : width of the one-hot grant vector
//   cnt_width : beat-counter width for a given burst cap (never below 1)
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam int GRANT_W = 2;

    // A cap of 0 means unlimited bursts; the counter then only needs one bit.
    function automatic int cnt_width(input int max_burst);
        int w;
        w = $clog2(max_burst + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux2_stream_arbiter_if.sv
// Single valid/ready stream bundle.
//   valid : source has a beat on data/last
//   data  : beat payload, WIDTH bits
//   last  : beat is the final one of a packet
//   ready : sink takes the beat this cycle
// Handshake: a beat transfers on every rising clk edge where valid and ready
// are both 1. Nothing transfers otherwise, and the source keeps data/last
// stable while valid is 1 and ready is 0.
// Modports: master drives valid/data/last, slave drives ready.
interface mux2_stream_arbiter_if #(
    parameter int WIDTH = 8
);

    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic             ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/mux2_1.sv
// One-bit two-input multiplexer cell.
//   y  : output, i0 when s=0, i1 when s=1
//   i0 : input selected by s=0
//   i1 : input selected by s=1
//   s  : select
module mux2_1 (
    output logic y,
    input  logic i0,
    input  logic i1,
    input  logic s
);

    assign y = s ? i1 : i0;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin arbiter sharing one output stream between two requesters.
// A grant is held for a whole packet or until MAX_BURST beats have been
// accepted (MAX_BURST=0: packet-atomic), then handed to the other side.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req0, req1 : requester streams (slave side)
//   out        : shared output stream (master side), data via mux2_1 bank
//   sel        : registered mux select, 1 only in GRANT1
//   grant      : registered one-hot grant, 00 in IDLE
//   dbg_state, dbg_cnt, dbg_prio : internal FSM state, beat counter, priority
module mux2_stream_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    localparam int CNT_W    = cnt_width(MAX_BURST)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux2_stream_arbiter_if.slave  req0,
    mux2_stream_arbiter_if.slave  req1,
    mux2_stream_arbiter_if.master out,
    output logic                 sel,
    output logic [GRANT_W-1:0]   grant,
    output state_t               dbg_state,
    output logic [CNT_W-1:0]     dbg_cnt,
    output logic                 dbg_prio
);

    state_t           state;
    state_t           nxt;
    logic             prio;
    logic [CNT_W-1:0] cnt;

    logic             cur_valid;
    logic             cur_last;
    logic             other_valid;
    state_t           other_grant;
    logic             beat;
    logic             cap_hit;
    logic             grant_end;
    logic [WIDTH-1:0] mux_y;

    // View of the currently granted side and its competitor.
    always_comb begin
        cur_valid   = 1'b0;
        cur_last    = 1'b0;
        other_valid = 1'b0;
        other_grant = GRANT0;
        case (state)
            GRANT0: begin
                cur_valid   = req0.valid;
                cur_last    = req0.last;
                other_valid = req1.valid;
                other_grant = GRANT1;
            end
            GRANT1: begin
                cur_valid   = req1.valid;
                cur_last    = req1.last;
                other_valid = req0.valid;
                other_grant = GRANT0;
            end
            default: begin
            end
        endcase
    end

    assign beat      = cur_valid & out.ready;
    assign cap_hit   = (MAX_BURST > 0) && ((int'(cnt) + 1) == MAX_BURST);
    assign grant_end = beat & (cur_last | cap_hit);

    // After a grant ends the other side wins if it is waiting. Otherwise a
    // packet cut short by the burst cap keeps its grant so the remainder can
    // follow without a detour through IDLE; a completed packet returns to IDLE.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req0.valid && req1.valid) begin
                    nxt = prio ? GRANT1 : GRANT0;
                end else if (req0.valid) begin
                    nxt = GRANT0;
                end else if (req1.valid) begin
                    nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (grant_end) begin
                    if (other_valid) begin
                        nxt = other_grant;
                    end else if (!cur_last) begin
                        nxt = state;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // sel and grant are decoded from the next state so they are registered
    // alongside it and always match the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= '0;
            sel   <= 1'b0;
            grant <= '0;
        end else begin
            state <= nxt;
            sel   <= (nxt == GRANT1);
            grant <= {nxt == GRANT1, nxt == GRANT0};
            if (grant_end) begin
                cnt  <= '0;
                prio <= (state == GRANT0);
            end else if (beat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out.valid  = cur_valid;
    assign out.last   = cur_last;
    assign req0.ready = (state == GRANT0) & out.ready;
    assign req1.ready = (state == GRANT1) & out.ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2_1 u_mux (
            .y  (mux_y[i]),
            .i0 (req0.data[i]),
            .i1 (req1.data[i]),
            .s  (sel)
        );
    end

    assign out.data  = mux_y;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;
    assign dbg_prio  = prio;

endmodule
